adder_rr_arbiter: RTL

- Shares one registered W-bit adder among N requesters under round-robin arbitration.
- Each requester offers an operand pair (a, b) over a valid/ready handshake. The block grants one requester and computes a+b with carry.
- The tagged result is returned on a single response channel with back-pressure.
- Sits between the user-facing input pins and the sum datapath, sequencing all access to the adder.

---
 rtl/adder_rr_arbiter.sv | 66 ++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one registered adder with a tagged, back-pressured result channel
module adder_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_sum,
  output logic           res_carry,
  output logic [IDW-1:0] res_id,
  output logic [15:0]    txn_count,
  output logic           busy
);
  typedef enum logic {IDLE, RESULT} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, g;
  logic hit, accept_ok, accept;
  logic [W-1:0] a_g, b_g;
  // first valid requester scanning from ptr upward with wrap; nearest to ptr wins
  always_comb begin
    hit = 1'b0;
    g = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[IDW'((int'(ptr) + k) % N)]) begin
        hit = 1'b1;
        g = IDW'((int'(ptr) + k) % N);
      end
  end
  // accept window opens when idle or when the held result is being drained this cycle
  always_comb begin
    accept_ok = !rst && (state == IDLE || res_ready);
    accept = accept_ok && hit;
    req_ready = accept ? N'(1) << g : '0;
    a_g = req_a[int'(g)*W +: W];
    b_g = req_b[int'(g)*W +: W];
    state_nx = (accept || (state == RESULT && !res_ready)) ? RESULT : IDLE;
  end
  assign res_valid = (state == RESULT);
  assign busy = (state == RESULT);
  // state, round-robin pointer, registered sum and transaction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      res_sum <= '0;
      res_carry <= 1'b0;
      res_id <= '0;
      txn_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        {res_carry, res_sum} <= {1'b0, a_g} + {1'b0, b_g};
        res_id <= g;
        ptr <= (g == IDW'(N - 1)) ? '0 : g + 1'b1;
        txn_count <= txn_count + 16'd1;
      end
    end
  end
endmodule
